regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
- REQ-001: Parameter DATA_WIDTH, default 64, width of each register and data port.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: reset_n  input  1  reset, asynchronous, active-low.
- REQ-004: RegWrite  input  1  write enable for the write port.
- REQ-005: WriteRegister  input  5  destination register index 0..31.
- REQ-006: WriteData  input  DATA_WIDTH  data written on the qualifying edge.
- REQ-007: ReadRegister1  input  5  read port 1 index.
- REQ-008: ReadRegister2  input  5  read port 2 index.
- REQ-009: ReadData1  output  DATA_WIDTH  contents of register ReadRegister1.
- REQ-010: ReadData2  output  DATA_WIDTH  contents of register ReadRegister2.

Function
- REQ-011: The block SHALL hold 32 registers X0..X31 of DATA_WIDTH bits each.
- REQ-012: WriteRegister SHALL be decoded to 32 one-hot enables, all gated by RegWrite, through a 5:32 decoder (2:4 stage feeding four 3:8 stages).
- REQ-013: On a rising clk edge with RegWrite=1, the register selected by WriteRegister SHALL load WriteData; all other registers SHALL hold.
- REQ-014: RegWrite=0 SHALL leave all 32 registers unchanged regardless of WriteRegister or WriteData.
- REQ-015: X31 SHALL be hardwired to zero: writes to index 31 are discarded, and reads of index 31 return 0 on both ports.
- REQ-016: Reads SHALL be combinational from the stored array, with zero-cycle latency from a change of ReadRegister1/2 to ReadData1/2.
- REQ-017: Both read ports SHALL be independent; both may select the same register, and both may select the write target in the same cycle.
- REQ-018: Without bypass (see Configuration), a write SHALL become visible on the read ports only after the capturing clk edge.
- REQ-019: Index values SHALL be used unsigned; no out-of-range case exists, because all 32 codes are valid.

Reset
- REQ-020: reset_n=0 SHALL immediately clear X0..X30 to 0, independent of clk, so that ReadData1 and ReadData2 read 0 for every index.
- REQ-021: While reset_n=0, writes SHALL be ignored, even with RegWrite=1 at a clk edge.
- REQ-022: A reset asserted mid-operation SHALL discard any write whose capturing edge coincides with reset assertion.
- REQ-023: After reset_n deasserts, the first rising edge with RegWrite=1 SHALL perform a normal write.

Configuration
- REQ-024: Macro REGFILE_BYPASS_EN defined: when RegWrite=1 and ReadRegisterN==WriteRegister!=31, ReadDataN SHALL equal WriteData combinationally in the same cycle (write-through forwarding), per port independently.
- REQ-025: REGFILE_BYPASS_EN undefined: no forwarding; ReadDataN SHALL show the stored (old) value until the capturing edge.
- REQ-026: In both configurations, index 31 SHALL read 0 and reset behaviour SHALL be identical.

Verification
- REQ-027: Reset: assert reset_n=0, sweep ReadRegister1/2 over 0..31 -> all reads 0; a RegWrite=1 edge during reset leaves X5=0.
- REQ-028: Write/readback: write X(i)=0x1111_0000_0000_0000+i for i=0..30, then read all -> each returns its value, and X31 reads 0.
- REQ-029: X31 and no-write: write 0xDEAD to index 31 -> ReadData1(31)=0; with RegWrite=0, WriteRegister=3 and WriteData=0xFFFF -> X3 unchanged.
- REQ-030: Same-cycle read/write, X7 holding 0xAA, RegWrite=1, WriteRegister=7, WriteData=0xBB, ReadRegister1=ReadRegister2=7: before the edge, ReadData1/2 = 0xBB with REGFILE_BYPASS_EN, or 0xAA without it; after the edge, 0xBB in both configurations.
- REQ-031: Async reset mid-run: with X10=0x55, drop reset_n between clk edges -> ReadData1(10)=0 within the same cycle, before any clk edge.

Source files
------------

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile: 32 x DATA_WIDTH register file with one write port and two
// independent combinational read ports. X31 is hardwired to zero.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> write-through forwarding: a read port addressing the
//                register being written this cycle sees WriteData at once.
//   undefined -> the read ports show the stored value until the capturing
//                clock edge.
//
// Ports
//   clk            in   rising-edge clock for all state updates
//   reset_n        in   asynchronous active-low reset, clears X0..X30
//   RegWrite       in   write enable
//   WriteRegister  in   [4:0] destination index
//   WriteData      in   [DATA_WIDTH-1:0] write data
//   ReadRegister1  in   [4:0] read port 1 index
//   ReadRegister2  in   [4:0] read port 2 index
//   ReadData1      out  [DATA_WIDTH-1:0] contents of ReadRegister1 (comb)
//   ReadData2      out  [DATA_WIDTH-1:0] contents of ReadRegister2 (comb)
// ---------------------------------------------------------------------------
module regfile #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  RegWrite,
    input  logic [4:0]            WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [4:0]            ReadRegister1,
    input  logic [4:0]            ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ZERO_IDX = 31;
    localparam int unsigned GRP_SIZE = 8;
    localparam int unsigned NUM_GRPS = NUM_REGS / GRP_SIZE;

    // 2:4 decoder with enable; first stage of the write-address decode
    function automatic logic [3:0] dec2to4(input logic en, input logic [1:0] sel);
        logic [3:0] y;
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
        return y;
    endfunction

    // 3:8 decoder with enable; one per group of eight registers
    function automatic logic [7:0] dec3to8(input logic en, input logic [2:0] sel);
        logic [7:0] y;
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
        return y;
    endfunction

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_GRPS-1:0]   w_grp_en;
    logic [NUM_REGS-1:0]   w_wen;
    logic                  w_fwd1;
    logic                  w_fwd2;

    // Upper index bits pick a group; RegWrite gates the whole tree here
    assign w_grp_en = dec2to4(RegWrite, WriteRegister[4:3]);

    // Lower index bits pick a register inside the enabled group
    for (genvar g = 0; g < NUM_GRPS; g++) begin : g_dec
        assign w_wen[g*GRP_SIZE +: GRP_SIZE] = dec3to8(w_grp_en[g], WriteRegister[2:0]);
    end

    // Storage; the X31 slot always reloads zero so a write to it is discarded
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wen[i]) begin
                    r_regs[i] <= (i == ZERO_IDX) ? '0 : WriteData;
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward only live writes to real registers; held off during reset so
    // every index reads zero while reset_n is low
    assign w_fwd1 = reset_n && RegWrite && (ReadRegister1 == WriteRegister)
                    && (WriteRegister != 5'(ZERO_IDX));
    assign w_fwd2 = reset_n && RegWrite && (ReadRegister2 == WriteRegister)
                    && (WriteRegister != 5'(ZERO_IDX));
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    // Read port 1: zero for X31, else forwarded or stored value
    always_comb begin
        ReadData1 = '0;
        if (ReadRegister1 != 5'(ZERO_IDX)) begin
            ReadData1 = w_fwd1 ? WriteData : r_regs[ReadRegister1];
        end
    end

    // Read port 2: same structure as port 1, fully independent
    always_comb begin
        ReadData2 = '0;
        if (ReadRegister2 != 5'(ZERO_IDX)) begin
            ReadData2 = w_fwd2 ? WriteData : r_regs[ReadRegister2];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile: scoreboard bench for regfile. Expected read values come from a
// bench-side register model; they are queued when read stimulus is applied
// and popped and compared once the combinational outputs have settled.
// ---------------------------------------------------------------------------
module tb_regfile;

    localparam int unsigned DW = 64;

    logic          clk;
    logic          reset_n;
    logic          RegWrite;
    logic [4:0]    WriteRegister;
    logic [DW-1:0] WriteData;
    logic [4:0]    ReadRegister1;
    logic [4:0]    ReadRegister2;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;

    regfile #(.DATA_WIDTH(DW)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        int            port;
        logic [DW-1:0] exp;
    } sb_entry_t;

    sb_entry_t     sb_q[$];
    logic [DW-1:0] model [32];
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [4:0] idx);
        return (idx == 5'd31) ? '0 : model[idx];
    endfunction

    // Queue expectations for both ports at the moment the indices are driven
    task automatic push_exp(input string tag, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        sb_entry_t e;
        e.tag = {tag, "_p1"}; e.port = 1; e.exp = e1; sb_q.push_back(e);
        e.tag = {tag, "_p2"}; e.port = 2; e.exp = e2; sb_q.push_back(e);
    endtask

    // Compare every queued expectation against the settled outputs
    task automatic drain;
        sb_entry_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, (e.port == 1) ? ReadData1 : ReadData2, e.exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [4:0] b);
        ReadRegister1 = a;
        ReadRegister2 = b;
        push_exp(tag, model_rd(a), model_rd(b));
        drain();
    endtask

    task automatic wr(input logic [4:0] idx, input logic [DW-1:0] data);
        RegWrite      = 1'b1;
        WriteRegister = idx;
        WriteData     = data;
        @(posedge clk);
        #1;
        if (idx != 5'd31 && reset_n) model[idx] = data;
        RegWrite = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0]    ra;
        logic [4:0]    rb;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_pre;

        for (int i = 0; i < 32; i++) model[i] = '0;
        reset_n       = 1'b0;
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        #2;

        // Reset sweep: every index reads zero on both ports
        for (int i = 0; i < 32; i++) rd("rst_sweep", 5'(i), 5'(31 - i));

        // Write attempt while in reset must be ignored
        wr(5'd5, 64'h1234_5678_9ABC_DEF0);
        rd("rst_wr_ignored", 5'd5, 5'd5);

        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill X0..X30 then read everything back
        for (int i = 0; i < 31; i++) wr(5'(i), 64'h1111_0000_0000_0000 + 64'(i));
        for (int i = 0; i < 32; i++) rd("readback", 5'(i), 5'(31 - i));

        // Write to X31 is discarded
        wr(5'd31, 64'hDEAD);
        rd("x31_zero", 5'd31, 5'd31);

        // RegWrite low leaves X3 untouched
        RegWrite      = 1'b0;
        WriteRegister = 5'd3;
        WriteData     = 64'hFFFF;
        @(posedge clk);
        #1;
        rd("no_write_x3", 5'd3, 5'd3);

        // Same-cycle read/write of X7, plus port 2 on an unrelated register
        wr(5'd7, 64'hAA);
        RegWrite      = 1'b1;
        WriteRegister = 5'd7;
        WriteData     = 64'hBB;
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd7;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 64'hBB;
`else
        exp_pre = 64'hAA;
`endif
        push_exp("same_cyc_pre", exp_pre, exp_pre);
        drain();
        ReadRegister2 = 5'd8;
        push_exp("same_cyc_other", exp_pre, model_rd(5'd8));
        drain();
        @(posedge clk);
        #1;
        model[7] = 64'hBB;
        RegWrite = 1'b0;
        rd("same_cyc_post", 5'd7, 5'd7);

        // Writing X31 while reading it: zero in both configurations
        RegWrite      = 1'b1;
        WriteRegister = 5'd31;
        WriteData     = 64'hCAFE;
        rd("x31_same_cyc", 5'd31, 5'd31);
        RegWrite = 1'b0;

        // Random writes interleaved with random dual reads
        for (int i = 0; i < 40; i++) begin
            d = {32'($urandom), 32'($urandom)};
            wr(5'($urandom_range(0, 31)), d);
            ra = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            rd("random", ra, rb);
        end

        // Async reset between edges clears X10 immediately
        wr(5'd10, 64'h55);
        rd("x10_before_rst", 5'd10, 5'd10);
        #2;
        reset_n = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        push_exp("async_rst", '0, '0);
        drain();

        // Edge with RegWrite high during reset leaves everything clear
        wr(5'd12, 64'h77);
        rd("rst_hold_wr", 5'd12, 5'd5);

        // First write after release behaves normally
        @(negedge clk);
        reset_n = 1'b1;
        wr(5'd12, 64'h99);
        rd("post_rst_wr", 5'd12, 5'd11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
